// File: rtl/uart_rx_buf_pkg.sv
// Shared constants and helpers for the UART receive frame buffer.
// Entry layout: {stp_err, par_err, payload[DATA_WIDTH-1:0]}.
// The fixed constants describe the default 8-bit payload. The helper
// functions give the same values for any payload width, so that parameter
// overrides in the modules stay consistent with the entry layout.
package uart_rx_buf_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int ENTRY_W        = DEF_DATA_WIDTH + 2;
    localparam int ENT_PAR        = DEF_DATA_WIDTH;
    localparam int ENT_STP        = DEF_DATA_WIDTH + 1;
    localparam int ERR_CNT_W      = 8;

    function automatic int entry_width(input int dw);
        return dw + 2;
    endfunction

    function automatic int par_idx(input int dw);
        return dw;
    endfunction

    function automatic int stp_idx(input int dw);
        return dw + 1;
    endfunction

endpackage

// File: rtl/uart_rx_buf_mem.sv
// Storage array for the UART receive frame buffer.
// It holds DEPTH x WIDTH registers, with a synchronous write port and an
// asynchronous read port, so the top can present a show-ahead head entry.
// The contents are not reset.
// Ports:
//   clk_i   - clock
//   we_i    - write enable
//   waddr_i - write address
//   wdata_i - write data
//   raddr_i - read address
//   rdata_o - read data (combinational from raddr_i)
module uart_rx_buf_mem #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_frame_buffer.sv
// Receive-side frame buffer placed directly after the UART receiver.
// On each data_valid strobe it queues the received byte together with its
// parity and stop error flags. The queued frames are presented on a
// show-ahead valid/ready read port.
// Ports:
//   CLK, RST           - clock; synchronous active-high reset
//   P_DATA, data_valid - received byte and its one-cycle strobe
//   par_err, stp_err   - receiver error levels, sampled with data_valid
//   rd_data, rd_par_err, rd_stp_err, rd_valid, rd_ready - read port
//   level, full        - registered occupancy (0..DEPTH) and full flag
//   overrun, clr_overrun - sticky drop flag and its clear
// Optional feature, enabled by defining the macro UART_RX_BUF_ERR_CNT_EN:
//   clr_cnt, par_err_cnt, stp_err_cnt - saturating 8-bit error counters
module uart_rx_frame_buffer
    import uart_rx_buf_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 8,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  data_valid,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_par_err,
    output logic                  rd_stp_err,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  full,
    output logic                  overrun,
`ifdef UART_RX_BUF_ERR_CNT_EN
    input  logic                  clr_cnt,
    output logic [ERR_CNT_W-1:0]  par_err_cnt,
    output logic [ERR_CNT_W-1:0]  stp_err_cnt,
`endif
    input  logic                  clr_overrun
);

    localparam int EW    = entry_width(DATA_WIDTH);
    localparam int E_PAR = par_idx(DATA_WIDTH);
    localparam int E_STP = stp_idx(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

    // Pointers carry one extra wrap bit, so full and empty are distinguishable.
    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] level_q, level_d;
    logic                full_q, full_d;
    logic                overrun_q, overrun_d;

    logic                push, pop, wr_en, drop;
    logic [EW-1:0]       wr_entry, rd_entry;

    assign push = data_valid;
    // rd_valid depends only on registered level, so data_valid has no
    // combinational path to it.
    assign rd_valid = (level_q != '0);
    assign pop      = rd_valid & rd_ready;
    // While full, a simultaneous pop frees the slot and the push still lands.
    assign wr_en    = push & (~full_q | pop);
    assign drop     = push & full_q & ~pop;

    assign wr_entry = {stp_err, par_err, P_DATA};

    always_comb begin
        wr_ptr_d  = wr_ptr_q + (ADDR_WIDTH+1)'(wr_en);
        rd_ptr_d  = rd_ptr_q + (ADDR_WIDTH+1)'(pop);
        level_d   = wr_ptr_d - rd_ptr_d;
        full_d    = (level_d == DEPTH_CNT);
        overrun_d = overrun_q;
        // A drop in the same cycle beats the clear.
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            full_q    <= full_d;
            overrun_q <= overrun_d;
        end
    end

    uart_rx_buf_mem #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (CLK),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata_o (rd_entry)
    );

    assign rd_data    = rd_entry[DATA_WIDTH-1:0];
    assign rd_par_err = rd_entry[E_PAR];
    assign rd_stp_err = rd_entry[E_STP];
    assign level      = level_q;
    assign full       = full_q;
    assign overrun    = overrun_q;

`ifdef UART_RX_BUF_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] par_cnt_q, par_cnt_d;
    logic [ERR_CNT_W-1:0] stp_cnt_q, stp_cnt_d;

    // Dropped pushes still count, because the error was seen on the line.
    // The clear wins over a coincident increment.
    always_comb begin
        par_cnt_d = par_cnt_q;
        stp_cnt_d = stp_cnt_q;
        if (clr_cnt) begin
            par_cnt_d = '0;
            stp_cnt_d = '0;
        end else begin
            if (push && par_err && (par_cnt_q != '1)) begin
                par_cnt_d = par_cnt_q + 1'b1;
            end
            if (push && stp_err && (stp_cnt_q != '1)) begin
                stp_cnt_d = stp_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            par_cnt_q <= '0;
            stp_cnt_q <= '0;
        end else begin
            par_cnt_q <= par_cnt_d;
            stp_cnt_q <= stp_cnt_d;
        end
    end

    assign par_err_cnt = par_cnt_q;
    assign stp_err_cnt = stp_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_frame_buffer.sv
// Self-checking bench for uart_rx_frame_buffer.
// The reference model is a queue of {stp, par, data} entries, a sticky
// overrun bit and, when UART_RX_BUF_ERR_CNT_EN is defined, two saturating
// counters.
module tb_uart_rx_frame_buffer;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          data_valid, par_err, stp_err, rd_ready, clr_overrun;
    logic [DW-1:0] rd_data;
    logic          rd_par_err, rd_stp_err, rd_valid, full, overrun;
    logic [AW:0]   level;
`ifdef UART_RX_BUF_ERR_CNT_EN
    logic          clr_cnt;
    logic [7:0]    par_err_cnt, stp_err_cnt;
`endif

    uart_rx_frame_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .P_DATA      (P_DATA),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .rd_data     (rd_data),
        .rd_par_err  (rd_par_err),
        .rd_stp_err  (rd_stp_err),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .level       (level),
        .full        (full),
        .overrun     (overrun),
`ifdef UART_RX_BUF_ERR_CNT_EN
        .clr_cnt     (clr_cnt),
        .par_err_cnt (par_err_cnt),
        .stp_err_cnt (stp_err_cnt),
`endif
        .clr_overrun (clr_overrun)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    logic [9:0] q[$];
    logic       m_ovr;
    int         m_pcnt, m_scnt;

    task automatic chk(input string name, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", name, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ":level"}, 16'(level), 16'(q.size()));
        chk({tag, ":rd_valid"}, 16'(rd_valid), 16'(q.size() != 0));
        chk({tag, ":full"}, 16'(full), 16'(q.size() == DEPTH));
        chk({tag, ":overrun"}, 16'(overrun), 16'(m_ovr));
        if (q.size() != 0) begin
            chk({tag, ":head"}, 16'({rd_stp_err, rd_par_err, rd_data}), 16'(q[0]));
        end
`ifdef UART_RX_BUF_ERR_CNT_EN
        chk({tag, ":par_cnt"}, 16'(par_err_cnt), 16'(m_pcnt));
        chk({tag, ":stp_cnt"}, 16'(stp_err_cnt), 16'(m_scnt));
`endif
    endtask

    // Drives one cycle of inputs, updates the model and checks after the edge.
    task automatic step(input string tag, input logic dv, input logic [7:0] d,
                        input logic pe, input logic se, input logic rdy,
                        input logic clro, input logic clrc);
        bit do_pop, was_full;
        P_DATA      = d;
        data_valid  = dv;
        par_err     = pe;
        stp_err     = se;
        rd_ready    = rdy;
        clr_overrun = clro;
`ifdef UART_RX_BUF_ERR_CNT_EN
        clr_cnt     = clrc;
`endif
        was_full = (q.size() == DEPTH);
        do_pop   = (q.size() != 0) && rdy;
        if (do_pop) begin
            chk({tag, ":pop"}, 16'({rd_stp_err, rd_par_err, rd_data}), 16'(q[0]));
            void'(q.pop_front());
        end
        if (dv) begin
            if (!was_full || do_pop) q.push_back({se, pe, d});
            else m_ovr = 1'b1;
        end
        if (!(dv && was_full && !do_pop) && clro) m_ovr = 1'b0;
        if (clrc) begin
            m_pcnt = 0;
            m_scnt = 0;
        end else begin
            if (dv && pe && m_pcnt < 255) m_pcnt++;
            if (dv && se && m_scnt < 255) m_scnt++;
        end
        @(posedge CLK);
        #1;
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        RST = 1'b1;
        data_valid = 1'b0;
        rd_ready = 1'b0;
        clr_overrun = 1'b0;
`ifdef UART_RX_BUF_ERR_CNT_EN
        clr_cnt = 1'b0;
`endif
        @(posedge CLK);
        #1;
        RST = 1'b0;
        q.delete();
        m_ovr = 1'b0;
        m_pcnt = 0;
        m_scnt = 0;
        check_state(tag);
    endtask

    initial begin
        RST = 1'b1; P_DATA = '0; data_valid = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        rd_ready = 1'b0; clr_overrun = 1'b0;
`ifdef UART_RX_BUF_ERR_CNT_EN
        clr_cnt = 1'b0;
`endif
        m_ovr = 1'b0; m_pcnt = 0; m_scnt = 0;
        @(posedge CLK);
        #1;
        do_reset("reset");

        // Single frame, one-cycle latency, then a pop.
        step("single_push", 1, 8'hA5, 0, 0, 0, 0, 0);
        chk("single_data", 16'(rd_data), 16'h00A5);
        chk("single_level", 16'(level), 16'd1);
        step("single_pop", 0, 8'h00, 0, 0, 1, 0, 0);
        chk("single_empty", 16'(rd_valid), 16'd0);

        // Fill and overrun on the ninth push.
        for (int i = 0; i <= 8; i++) step("fill", 1, 8'(i), 0, 0, 0, 0, 0);
        chk("fill_full", 16'(full), 16'd1);
        chk("fill_level", 16'(level), 16'd8);
        chk("fill_overrun", 16'(overrun), 16'd1);

        // Clear overrun, then a push while full with a simultaneous pop.
        step("clr_ovr", 0, 8'h00, 0, 0, 0, 1, 0);
        step("full_pop_push", 1, 8'h55, 0, 0, 1, 0, 0);
        chk("full_pop_level", 16'(level), 16'd8);
        chk("full_pop_ovr", 16'(overrun), 16'd0);
        for (int i = 0; i < DEPTH - 1; i++) step("drain", 0, 8'h00, 0, 0, 1, 0, 0);
        chk("last_is_55", 16'(rd_data), 16'h0055);
        step("drain_last", 0, 8'h00, 0, 0, 1, 0, 0);
        chk("drained", 16'(rd_valid), 16'd0);

        // Error flags on the head entry.
        step("err_push", 1, 8'h3C, 1, 0, 0, 0, 0);
        chk("err_par", 16'(rd_par_err), 16'd1);
        chk("err_stp", 16'(rd_stp_err), 16'd0);
        step("err_pop", 0, 8'h00, 0, 0, 1, 0, 0);

        // Pointer wrap-around with streaming push/pop pairs.
        step("wrap_first", 1, 8'($urandom), 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            step("wrap", 1, 8'($urandom), 1'($urandom), 1'($urandom), 1, 0, 0);
        step("wrap_end", 0, 8'h00, 0, 0, 1, 0, 0);

        // Reset mid-operation with five queued frames.
        for (int i = 0; i < 5; i++) step("pre_rst", 1, 8'($urandom), 0, 0, 0, 0, 0);
        chk("pre_rst_level", 16'(level), 16'd5);
        do_reset("mid_reset");

        // Overrun set beats a coincident clear.
        for (int i = 0; i < DEPTH; i++) step("fill2", 1, 8'($urandom), 0, 0, 0, 0, 0);
        step("drop_clr", 1, 8'hEE, 0, 0, 0, 1, 0);
        chk("drop_clr_ovr", 16'(overrun), 16'd1);
        do_reset("reset2");

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            step("rand", 1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 31) == 0));

`ifdef UART_RX_BUF_ERR_CNT_EN
        do_reset("cnt_reset");
        for (int i = 0; i < 300; i++) step("cnt", 1, 8'(i), 0, 1, 1, 0, 0);
        chk("stp_sat", 16'(stp_err_cnt), 16'd255);
        chk("par_zero", 16'(par_err_cnt), 16'd0);
        step("cnt_clr", 0, 8'h00, 0, 0, 1, 0, 1);
        chk("stp_clr", 16'(stp_err_cnt), 16'd0);
        chk("par_clr", 16'(par_err_cnt), 16'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_buffer.md
# uart_rx_frame_buffer

Receive-side frame buffer that sits directly downstream of the UART receiver. It captures each received byte and its parity and stop error flags on the receiver's one-cycle `data_valid` strobe, and queues them in a small FIFO. Frames are presented to the system bus through a valid/ready read port. The block also reports fill level and a sticky overrun flag, and optionally keeps saturating error counters.

## Interface
- `DATA_WIDTH`, default 8: payload width; must match the receiver's `P_DATA`.
- `DEPTH`, default 8: number of FIFO entries; must be a power of 2 and at least 2.
- `ADDR_WIDTH`, default `$clog2(DEPTH)`: pointer width; derived, not overridden.
- `CLK` input 1: single clock, shared with the receiver.
- `RST` input 1: reset; one clock; reset is synchronous and active-high.
- `P_DATA` input DATA_WIDTH: received byte from the receiver.
- `data_valid` input 1: one-cycle frame-complete strobe from the receiver.
- `par_err` input 1: receiver parity error, as a level.
- `stp_err` input 1: receiver stop error, as a level.
- `rd_data` output DATA_WIDTH: head-entry payload.
- `rd_par_err` output 1: head-entry parity error bit.
- `rd_stp_err` output 1: head-entry stop error bit.
- `rd_valid` output 1: FIFO is not empty.
- `rd_ready` input 1: consumer accepts the head entry.
- `level` output ADDR_WIDTH+1: occupancy, from 0 to DEPTH.
- `full` output 1: `level == DEPTH`.
- `overrun` output 1: sticky flag; set when a frame is dropped.
- `clr_overrun` input 1: clears `overrun`.
- `clr_cnt` input 1: clears the error counters. Present only with `UART_RX_BUF_ERR_CNT_EN`.
- `par_err_cnt` output 8: saturating parity-error count. Present only with the macro.
- `stp_err_cnt` output 8: saturating stop-error count. Present only with the macro.

## Operation
- **Push.** A push occurs when `data_valid` is high.
  - The entry written is {`stp_err`, `par_err`, `P_DATA`}, with the error flags sampled in the same cycle.
  - The entry goes to `mem[wr_ptr]`, then `wr_ptr` increments.
- **Pop.** A pop occurs when `rd_valid && rd_ready`; `rd_ptr` increments.
- **Read port.** The read port is show-ahead: `rd_data`, `rd_par_err` and `rd_stp_err` reflect `mem[rd_ptr]` combinationally.
  - These outputs are don't-care while `rd_valid` is low.
- **Pointers.** Pointers are ADDR_WIDTH+1 bits wide, and the MSB is the wrap bit.
  - `level = wr_ptr - rd_ptr`, computed modulo 2^(ADDR_WIDTH+1).
  - Wrap-around from DEPTH-1 to 0 is natural, with no special case.
- **Full without a pop.** A push while full with no pop in the same cycle is dropped.
  - Memory and pointers are unchanged.
  - `overrun` is set on the next edge.
- **Full with a pop.** A push while full with a simultaneous pop is accepted: the pop frees the slot and `level` stays at DEPTH.
- **Empty.** A push into an empty FIFO is accepted. A pop while empty is impossible, because `rd_valid` is low.
- **Simultaneous push and pop when not full or empty.** Both occur and `level` is unchanged.
- **Overrun priority.** `overrun` setting has priority over `clr_overrun` in the same cycle.
- **Flow control.** The block never back-pressures the receiver, which has no ready input. Dropping with `overrun` is the only overflow response.
- **Reset** (synchronous; takes effect on the edge while `RST` is high):
  - Pointers and `level` go to 0; `rd_valid`, `full` and `overrun` go to 0.
  - Counters go to 0. Memory contents are not reset.
  - Reset mid-operation discards all queued frames.

## Timing
- **Push to read.** A push at edge N makes `rd_valid` high and `level` update after edge N. Latency is 1 cycle, with no combinational path from `data_valid` to `rd_valid`.
- **Pop.** A pop at edge N presents the next entry, or deasserts `rd_valid`, after edge N.
- **Registered outputs.** `full`, `level`, `overrun` and the counters are registered; the counters update 1 cycle after the causing strobe.
- **Sustained throughput.** One push and one pop per cycle.

## Configuration
- **Macro `UART_RX_BUF_ERR_CNT_EN` defined:**
  - `clr_cnt`, `par_err_cnt` and `stp_err_cnt` exist.
  - Each counter increments on a push (dropped pushes included) whose corresponding error flag is high.
  - Each counter saturates at 255.
  - `clr_cnt` clears both counters. If `clr_cnt` coincides with an increment, the counter goes to 0 (clear wins).
- **Macro undefined:** those three ports and all counter logic are absent; FIFO behaviour is identical.

## Structure
- **Package `uart_rx_buf_pkg`:**
  - Entry width constant `ENTRY_W = DATA_WIDTH+2`.
  - Field index constants `ENT_PAR = DATA_WIDTH` and `ENT_STP = DATA_WIDTH+1`.
  - Counter width constant `ERR_CNT_W = 8`.
- **Sub-module `uart_rx_buf_mem`:**
  - DEPTH x ENTRY_W register array with a synchronous write port and an asynchronous read port.
  - Pointer, flag and counter logic stay in the top module.

## Test plan
- **Single frame.** After reset, pulse `data_valid` with `P_DATA=0xA5` and no errors; hold `rd_ready=0`.
  - Expect `rd_valid=1`, `rd_data=0xA5` and `level=1` one cycle later.
  - Then set `rd_ready=1` for one cycle; expect `level=0` and `rd_valid=0`.
- **Fill, overrun, drain.** With DEPTH=8, push 0x00 through 0x08 with `rd_ready=0`.
  - Expect `full=1`, `level=8`, and `overrun=1` after the ninth push.
  - Drain and expect exactly 0x00 through 0x07, in order.
- **Full with simultaneous pop.** With the FIFO full, push 0x55 while popping.
  - Expect the push accepted, `level` remaining 8, `overrun` staying 0, and 0x55 read last.
- **Error flags and wrap-around.**
  - Push 0x3C with `par_err=1` and read it; expect `rd_par_err=1` and `rd_stp_err=0`.
  - Run 20 push/pop pairs; expect data order preserved across pointer wrap.
- **Reset and overrun control.**
  - Assert `RST` for 1 cycle with `level=5`; expect `level=0`, `rd_valid=0` and `overrun=0` after that edge.
  - Assert `clr_overrun` in the same cycle as a dropping push; expect `overrun=1`.
- **Counters (macro defined).** Push 300 frames with `stp_err=1`.
  - Expect `stp_err_cnt=255`, saturated, and `par_err_cnt=0`.
  - Pulse `clr_cnt`; expect both counters at 0.
